prio_encod_rr: RTL and testbench

//  Parametrised, registered N-to-log2(N) priority encoder. Generalises the 4x2 one-hot encoder.
//  - Any number of request bits may be set; a multi-hot flag reports when more than one is.
//  - Mode select: fixed priority (highest index wins) or round-robin (rotating pointer).
//  - Output side uses a valid/ready handshake, so it can feed arbiter and mux-select logic.

---
 rtl/prio_encod_rr_if.sv | 34 +++
 rtl/prio_encod_rr.sv | 109 ++++++++++
 tb/tb_prio_encod_rr.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/prio_encod_rr_if.sv
// Request/result bundle for the prio_encod_rr priority encoder.
//  master : produces the request side (enable, mode, bin, bready) and
//           observes the registered result (bout, bvalid, multi).
//  slave  : the encoder itself; consumes requests and drives the result.
// Signals
//  enable  1  sample bin this cycle (subject to the accept rule)
//  mode    1  0 = fixed priority, 1 = round-robin
//  bin     N  request vector, bit i = request i
//  bready  1  downstream ready for bout
//  bout    W  encoded index of the selected request
//  bvalid  1  bout/multi hold a result not yet consumed
//  multi   1  more than one bin bit was set at accept
interface prio_encod_rr_if #(
  parameter int N = 4,
  parameter int W = 2
);
  logic         enable;
  logic         mode;
  logic [N-1:0] bin;
  logic         bready;
  logic [W-1:0] bout;
  logic         bvalid;
  logic         multi;

  modport master (
    output enable, mode, bin, bready,
    input  bout, bvalid, multi
  );

  modport slave (
    input  enable, mode, bin, bready,
    output bout, bvalid, multi
  );
endinterface

// File: rtl/prio_encod_rr.sv
// Registered N-to-log2(N) priority encoder with fixed-priority and
// round-robin modes and a valid/ready result handshake.
// Ports
//  clk  in   rising-edge clock
//  rst  in   synchronous active-high reset (overrides everything)
//  bus  slave modport of prio_encod_rr_if (request in, result out)
// A new request is accepted when enable is high, at least one request bit
// is set, and the output slot is free or being drained this same cycle.
// The result appears one cycle after accept.
module prio_encod_rr #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst,
  prio_encod_rr_if.slave bus
);

  localparam logic [W-1:0] PTR_RST = W'(N - 1);

  logic [W-1:0] bout_q,   bout_d;
  logic         bvalid_q, bvalid_d;
  logic         multi_q,  multi_d;
  logic [W-1:0] ptr_q,    ptr_d;

  logic [W-1:0] fix_sel_s;
  logic [W-1:0] rr_sel_s;
  logic         rr_found_s;
  logic [W-1:0] sel_s;
  logic         multi_hot_s;
  logic         accept_s;

  // Fixed priority: the last set bit scanned upward is the highest index.
  always_comb begin
    fix_sel_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      fix_sel_s = bus.bin[i] ? W'(i) : fix_sel_s;
    end
  end

  // Round-robin: scan ptr, ptr-1, ... downward with W-bit wrap, first hit wins.
  always_comb begin : rr_scan
    logic [W-1:0] idx_v;
    rr_sel_s   = ptr_q;
    rr_found_s = 1'b0;
    idx_v      = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx_v = ptr_q - W'(k);
      if (!rr_found_s && bus.bin[idx_v]) begin
        rr_sel_s   = idx_v;
        rr_found_s = 1'b1;
      end else begin
        rr_sel_s   = rr_sel_s;
        rr_found_s = rr_found_s;
      end
    end
  end

  // Select, multi-hot detect and the accept condition.
  always_comb begin
    sel_s       = bus.mode ? rr_sel_s : fix_sel_s;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_hot_s = (bus.bin & (bus.bin - N'(1))) != {N{1'b0}};
    accept_s    = bus.enable & (|bus.bin) & (~bvalid_q | bus.bready);
  end

  // Next-state: accept replaces the result, otherwise a ready drains it.
  always_comb begin
    bout_d   = bout_q;
    bvalid_d = bvalid_q;
    multi_d  = multi_q;
    ptr_d    = ptr_q;
    if (accept_s) begin
      bout_d   = sel_s;
      multi_d  = multi_hot_s;
      bvalid_d = 1'b1;
      if (bus.mode) begin
        // Next scan starts just below the winner, so the winner goes last.
        ptr_d = (sel_s == {W{1'b0}}) ? PTR_RST : (sel_s - W'(1));
      end else begin
        ptr_d = ptr_q;
      end
    end else if (bvalid_q && bus.bready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bout_q   <= {W{1'b0}};
      bvalid_q <= 1'b0;
      multi_q  <= 1'b0;
      ptr_q    <= PTR_RST;
    end else begin
      bout_q   <= bout_d;
      bvalid_q <= bvalid_d;
      multi_q  <= multi_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.bout   = bout_q;
  assign bus.bvalid = bvalid_q;
  assign bus.multi  = multi_q;

endmodule

// File: tb/tb_prio_encod_rr.sv
// Bench for prio_encod_rr: drives an N=4 and an N=8 instance in lockstep,
// compares every cycle against a behavioural model, and adds directed
// checks on the documented scenarios.
module tb_prio_encod_rr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prio_encod_rr_if #(.N(4), .W(2)) bus4 ();
  prio_encod_rr_if #(.N(8), .W(3)) bus8 ();

  prio_encod_rr #(.N(4), .W(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  prio_encod_rr #(.N(8), .W(3)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int total = 0;
  int bad   = 0;

  // Model state: valid, bout, multi, pointer for each instance.
  int v4 = 0, o4 = 0, m4 = 0, p4 = 3;
  int v8 = 0, o8 = 0, m8 = 0, p8 = 7;

  task automatic model_step(input int n, input logic r, input logic en,
                            input logic md, input logic rdy, input logic [7:0] b,
                            inout int v, inout int o, inout int m, inout int p);
    int  sel;
    bit  found;
    sel   = 0;
    found = 1'b0;
    if (r) begin
      v = 0; o = 0; m = 0; p = n - 1;
    end else if (en && (b != 8'd0) && (v == 0 || rdy)) begin
      if (md) begin
        for (int k = 0; k < n; k++) begin
          int idx;
          idx = (p - k + n) % n;
          if (!found && b[idx]) begin sel = idx; found = 1'b1; end
        end
        p = (sel + n - 1) % n;
      end else begin
        for (int i = n - 1; i >= 0; i--) begin
          if (!found && b[i]) begin sel = i; found = 1'b1; end
        end
      end
      o = sel;
      m = ($countones(b) > 1) ? 1 : 0;
      v = 1;
    end else if (v != 0 && rdy) begin
      v = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the model with the pre-edge inputs, check both DUTs.
  task automatic cycle(input string tag, input logic en, input logic md,
                       input logic [3:0] b4, input logic [7:0] b8,
                       input logic rdy, input logic r);
    rst         = r;
    bus4.enable = en;  bus8.enable = en;
    bus4.mode   = md;  bus8.mode   = md;
    bus4.bready = rdy; bus8.bready = rdy;
    bus4.bin    = b4;
    bus8.bin    = b8;
    @(posedge clk);
    model_step(4, r, en, md, rdy, {4'd0, b4}, v4, o4, m4, p4);
    model_step(8, r, en, md, rdy, b8,         v8, o8, m8, p8);
    #1;
    chk({tag, ".bvalid4"}, 32'(bus4.bvalid), 32'(v4));
    chk({tag, ".bout4"},   32'(bus4.bout),   32'(o4));
    chk({tag, ".multi4"},  32'(bus4.multi),  32'(m4));
    chk({tag, ".bvalid8"}, 32'(bus8.bvalid), 32'(v8));
    chk({tag, ".bout8"},   32'(bus8.bout),   32'(o8));
    chk({tag, ".multi8"},  32'(bus8.multi),  32'(m8));
  endtask

  initial begin
    logic [3:0] seq4 [4];
    logic [3:0] rb4;
    logic [7:0] rb8;
    seq4[0] = 4'b1000; seq4[1] = 4'b0100; seq4[2] = 4'b0010; seq4[3] = 4'b0001;

    // 1. Reset with active requests: everything stays cleared.
    cycle("rst0", 1'b1, 1'b0, 4'b1111, 8'hFF, 1'b1, 1'b1);
    cycle("rst1", 1'b1, 1'b0, 4'b1111, 8'hFF, 1'b1, 1'b1);
    chk("rst.bvalid", 32'(bus4.bvalid), 32'd0);
    chk("rst.bout",   32'(bus4.bout),   32'd0);
    chk("rst.multi",  32'(bus4.multi),  32'd0);

    // 2. Fixed priority, one-hot walk, then idle drain.
    for (int i = 0; i < 4; i++) begin
      cycle("fix1h", 1'b1, 1'b0, seq4[i], {4'd0, seq4[i]}, 1'b1, 1'b0);
      chk("fix1h.bout", 32'(bus4.bout), 32'(3 - i));
      chk("fix1h.multi", 32'(bus4.multi), 32'd0);
    end
    cycle("idle", 1'b0, 1'b0, 4'b0000, 8'h00, 1'b1, 1'b0);
    chk("idle.bvalid", 32'(bus4.bvalid), 32'd0);

    // 3. Fixed priority, multi-hot.
    cycle("fixmh0", 1'b1, 1'b0, 4'b1010, 8'h0A, 1'b1, 1'b0);
    chk("fixmh0.bout", 32'(bus4.bout), 32'd3);
    chk("fixmh0.multi", 32'(bus4.multi), 32'd1);
    cycle("fixmh1", 1'b1, 1'b0, 4'b0011, 8'h03, 1'b1, 1'b0);
    chk("fixmh1.bout", 32'(bus4.bout), 32'd1);
    chk("fixmh1.multi", 32'(bus4.multi), 32'd1);

    // 4. Round-robin on all requests: pointer starts at 3 after reset.
    for (int i = 0; i < 6; i++) begin
      cycle("rrall", 1'b1, 1'b1, 4'b1111, 8'h0F, 1'b1, 1'b0);
      chk("rrall.bout", 32'(bus4.bout), 32'((3 - i + 8) % 4));
    end
    for (int i = 0; i < 4; i++) begin
      cycle("rr0101", 1'b1, 1'b1, 4'b0101, 8'h05, 1'b1, 1'b0);
    end

    // 5. Backpressure holds the result; release replaces it with no bubble.
    cycle("bp0", 1'b1, 1'b0, 4'b0100, 8'h04, 1'b1, 1'b0);
    chk("bp0.bout", 32'(bus4.bout), 32'd2);
    cycle("bp1", 1'b1, 1'b1, 4'b0001, 8'h01, 1'b0, 1'b0);
    cycle("bp2", 1'b1, 1'b0, 4'b1000, 8'h80, 1'b0, 1'b0);
    cycle("bp3", 1'b1, 1'b1, 4'b0011, 8'h33, 1'b0, 1'b0);
    chk("bp3.bout", 32'(bus4.bout), 32'd2);
    chk("bp3.bvalid", 32'(bus4.bvalid), 32'd1);
    cycle("bp4", 1'b1, 1'b0, 4'b0001, 8'h01, 1'b1, 1'b0);
    chk("bp4.bout", 32'(bus4.bout), 32'd0);
    chk("bp4.bvalid", 32'(bus4.bvalid), 32'd1);

    // 6. Mid-operation reset returns the pointer to N-1.
    cycle("mr0", 1'b1, 1'b1, 4'b0100, 8'h04, 1'b1, 1'b0);
    chk("mr0.bout", 32'(bus4.bout), 32'd2);
    cycle("mr1", 1'b1, 1'b1, 4'b0100, 8'h04, 1'b1, 1'b1);
    chk("mr1.bvalid", 32'(bus4.bvalid), 32'd0);
    cycle("mr2", 1'b1, 1'b1, 4'b1111, 8'hFF, 1'b1, 1'b0);
    chk("mr2.bout4", 32'(bus4.bout), 32'd3);
    chk("mr2.bout8", 32'(bus8.bout), 32'd7);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rb4 = 4'($urandom);
      rb8 = 8'($urandom);
      cycle("rand",
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            rb4, rb8,
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
